// File: rtl/vram_wr_arbiter_pkg.sv
// vram_wr_arbiter_pkg: VRAM bus widths and fill-engine state encoding shared by the VRAM-side blocks
package vram_wr_arbiter_pkg;
  localparam int VRAM_AW = 13;
  localparam int VRAM_DW = 8;
  typedef enum logic {FILL_IDLE = 1'b0, FILL_RUN = 1'b1} fillState_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with show-ahead output
//   clk/rst: clock and async active-high reset; push/din: write side
//   pop/dout: read side, dout valid while !empty; count: current occupancy
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  always_ff @(posedge clk) if (push) mem[wrPtr] <= din;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      wrPtr <= wrPtr + AW'(push);
      rdPtr <= rdPtr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  assign dout = mem[rdPtr];
  assign empty = count == '0;
endmodule

// File: rtl/vram_wr_arbiter.sv
// vram_wr_arbiter: shares the VRAM write port between buffered host writes and a constant-fill engine
//   host:  hostWrAddr/Data/Valid in, hostWrReady out (registered)
//   fill:  fillStart/Addr/Len/Data in, fillBusy/fillDone out
//   vram:  vramWrAddr/Data/vramWr out, all registered
module vram_wr_arbiter
  import vram_wr_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int HOST_BURST = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [VRAM_AW-1:0] hostWrAddr,
  input  logic [VRAM_DW-1:0] hostWrData,
  input  logic               hostWrValid,
  output logic               hostWrReady,
  input  logic               fillStart,
  input  logic [VRAM_AW-1:0] fillAddr,
  input  logic [VRAM_AW-1:0] fillLen,
  input  logic [VRAM_DW-1:0] fillData,
  output logic               fillBusy,
  output logic               fillDone,
  output logic [VRAM_AW-1:0] vramWrAddr,
  output logic [VRAM_DW-1:0] vramWrData,
  output logic               vramWr
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(HOST_BURST + 1);
  fillState_t state, stateNext;
  logic [VRAM_AW-1:0] fillAddrQ, fillRem;
  logic [VRAM_DW-1:0] fillDataQ;
  logic [SW-1:0] streak;
  logic [VRAM_AW+VRAM_DW-1:0] fifoOut;
  logic [CW-1:0] fifoCount, nextCount;
  logic fifoEmpty, hostPush, hostReq, fillReq, hostGrant, fillGrant, lastFill, startOk;
  assign hostPush = hostWrValid && hostWrReady;
  assign nextCount = fifoCount + CW'(hostPush) - CW'(hostGrant);
  sync_fifo #(.WIDTH(VRAM_AW + VRAM_DW), .DEPTH(FIFO_DEPTH)) hostFifo (
    .clk(clk),
    .rst(rst),
    .push(hostPush),
    .din({hostWrAddr, hostWrData}),
    .pop(hostGrant),
    .dout(fifoOut),
    .count(fifoCount),
    .empty(fifoEmpty)
  );
  // Host wins unless it has already taken HOST_BURST grants in a row against a running fill.
  always_comb begin
    hostReq = !fifoEmpty;
    fillReq = state == FILL_RUN;
    hostGrant = hostReq && (!fillReq || streak != SW'(HOST_BURST));
    fillGrant = fillReq && !hostGrant;
    lastFill = fillGrant && fillRem == VRAM_AW'(1);
    startOk = fillStart && !fillBusy;
    stateNext = fillReq ? (lastFill ? FILL_IDLE : FILL_RUN)
                        : ((startOk && fillLen != '0) ? FILL_RUN : FILL_IDLE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL_IDLE;
    else state <= stateNext;
  end
  // fillBusy covers the cycle carrying the final write, so a new start cannot overlap fillDone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hostWrReady <= 1'b0;
      fillBusy <= 1'b0;
      fillDone <= 1'b0;
      streak <= '0;
      vramWr <= 1'b0;
      vramWrAddr <= '0;
      vramWrData <= '0;
      fillAddrQ <= '0;
      fillRem <= '0;
      fillDataQ <= '0;
    end else begin
      hostWrReady <= nextCount < CW'(FIFO_DEPTH);
      fillBusy <= fillReq || stateNext == FILL_RUN;
      fillDone <= lastFill || (startOk && fillLen == '0);
      streak <= (!fillReq || fillGrant) ? '0 : hostGrant ? streak + SW'(1) : streak;
      vramWr <= hostGrant || fillGrant;
      if (hostGrant) {vramWrAddr, vramWrData} <= fifoOut;
      else if (fillGrant) {vramWrAddr, vramWrData} <= {fillAddrQ, fillDataQ};
      if (!fillReq && startOk) begin
        fillAddrQ <= fillAddr;
        fillRem <= fillLen;
        fillDataQ <= fillData;
      end else if (fillGrant) begin
        fillAddrQ <= fillAddrQ + VRAM_AW'(1);
        fillRem <= fillRem - VRAM_AW'(1);
      end
    end
  end
endmodule
